uart_rx_stat: RTL

Serial UART receiver with a small receive FIFO. It produces the 2-bit UART status word that the register file returns on reads of the US register, and the received byte the core reads. It sits upstream of the register file. Its us output wires directly to the register file's us input.

---
 rtl/uart_rx_stat.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_stat.sv
// uart_rx_stat: 8N1 serial receiver feeding a small show-ahead FIFO, plus
// the 2-bit status word read back through the register file's US register.
//
// Ports:
//   clk      system clock, everything on posedge
//   rst_n    synchronous active-low reset
//   rx       asynchronous serial line, idle high, LSB first
//   pop      drop the FIFO head this cycle (ignored when empty)
//   err_clr  clear the sticky error bit (a new error in the same cycle wins)
//   rx_data  FIFO head byte, 8'h00 when empty
//   us       {sticky error (framing/overrun), FIFO non-empty}
//
// Receiver FSM:
//   state       | meaning
//   ------------+-----------------------------------------------------------
//   S_IDLE      | line idle, waiting for a falling edge on the synced line
//   S_START     | half-bit wait, then confirm start bit is still low
//   S_DATA      | sample 8 data bits at bit-centre, LSB first
//   S_STOP      | one bit wait, sample stop bit; push byte or flag framing
//   S_WAIT_HIGH | after a framing error, hold off until the line goes high

module uart_rx_stat #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       pop,
  input  logic       err_clr,
  output logic [7:0] rx_data,
  output logic [1:0] us
);

  localparam int TW   = $clog2(CLKS_PER_BIT);
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = PW + 1;

  localparam logic [TW-1:0]   BIT_LOAD  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0]   HALF_LOAD = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNTW-1:0] FULL_CNT  = CNTW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  // Two-flop synchronizer; both reset high so reset never looks like a start bit.
  logic rx_meta_q, rxs_q;

  state_t        state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic            err_q, err_d;

  logic push, frame_err;
  logic do_pop, do_push, overrun, full;

  // Receiver next-state. Timers are down-counters; the action happens on the
  // cycle the counter reads zero.
  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    push      = 1'b0;
    frame_err = 1'b0;
    case (state_q)
      S_IDLE: begin
        bit_cnt_d = '0;
        if (!rxs_q) begin
          state_d = S_START;
          tmr_d   = HALF_LOAD;
        end
      end
      S_START: begin
        if (tmr_q != '0) begin
          tmr_d = tmr_q - TW'(1);
        end else if (rxs_q) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DATA;
          tmr_d   = BIT_LOAD;
        end
      end
      S_DATA: begin
        if (tmr_q != '0) begin
          tmr_d = tmr_q - TW'(1);
        end else begin
          shift_d = {rxs_q, shift_q[7:1]};
          tmr_d   = BIT_LOAD;
          if (bit_cnt_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (tmr_q != '0) begin
          tmr_d = tmr_q - TW'(1);
        end else if (rxs_q) begin
          push    = 1'b1;
          state_d = S_IDLE;
        end else begin
          frame_err = 1'b1;
          state_d   = S_WAIT_HIGH;
        end
      end
      S_WAIT_HIGH: begin
        if (rxs_q) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO control. A pop frees a slot in the same cycle, so a push into a full
  // FIFO alongside a pop is accepted rather than treated as overrun.
  always_comb begin
    full     = (count_q == FULL_CNT);
    do_pop   = pop && (count_q != '0);
    do_push  = push && (!full || do_pop);
    overrun  = push && full && !do_pop;
    wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CNTW'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CNTW'(1);
    end
    if (frame_err || overrun) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
      state_q   <= S_IDLE;
      tmr_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rxs_q     <= rx_meta_q;
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      err_q     <= err_d;
    end
  end

  // Storage needs no reset: entries are only visible while count_q covers them.
  always_ff @(posedge clk) begin
    if (rst_n && do_push) begin
      mem_q[wr_ptr_q] <= shift_q;
    end
  end

  assign rx_data = (count_q != '0) ? mem_q[rd_ptr_q] : 8'h00;
  assign us      = {err_q, (count_q != '0)};

endmodule
